// File: rtl/count_mon_pkg.sv
// -----------------------------------------------------------------------------
// count_mon_pkg
//
// Shared definitions for the count_wrap_monitor slice: FSM state encodings
// (also driven out on state_out, so software sees these exact values) and the
// default widths used by the monitor and its step checker.
// -----------------------------------------------------------------------------
package count_mon_pkg;

    // FSM state encodings, visible on state_out
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_TRACK = 2'd1;
    localparam logic [1:0] ST_ALARM = 2'd2;

    // Default widths
    localparam int CNT_W_DEF      = 4;
    localparam int WRAP_CNT_W_DEF = 8;

endpackage : count_mon_pkg

// File: rtl/count_step_checker.sv
// -----------------------------------------------------------------------------
// count_step_checker
//
// Holds the previous enabled sample of the upstream down-counter and
// classifies the current sample against it. The classification flags are
// combinational from the registered previous value, so the parent can act on
// them on the same clock edge that captures the new sample.
//
// Ports:
//   clk          in   clock, rising edge
//   reset        in   asynchronous, active-high
//   enable_i     in   sample strobe; low clears prev_valid
//   cnt_i        in   current count from the upstream counter
//   step_ok_o    out  cnt_i == prev - 1 (mod 2^CNT_W)
//   step_hold_o  out  cnt_i == prev (counter stalled)
//   step_bad_o   out  neither of the above
//   is_wrap_o    out  legal step from 0 to all-ones
//
// All flags are qualified by prev_valid, so they are low on the first sample
// after reset or after an enable gap.
// -----------------------------------------------------------------------------
module count_step_checker
    import count_mon_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable_i,
    input  logic [CNT_W-1:0] cnt_i,
    output logic             step_ok_o,
    output logic             step_hold_o,
    output logic             step_bad_o,
    output logic             is_wrap_o
);

    logic [CNT_W-1:0] prev_q;
    logic [CNT_W-1:0] prev_d;
    logic             prev_valid_q;
    logic             prev_valid_d;
    logic [CNT_W-1:0] exp_cnt;

    // Every enabled sample becomes the new reference, legal or not, so a
    // single glitch produces a single error rather than a cascade.
    always_comb begin
        prev_d       = enable_i ? cnt_i : prev_q;
        prev_valid_d = enable_i;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
        end else begin
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
        end
    end

    // Modular decrement: expected successor of 0 is all-ones
    assign exp_cnt = prev_q - CNT_W'(1);

    assign step_ok_o   = prev_valid_q && (cnt_i == exp_cnt);
    assign step_hold_o = prev_valid_q && (cnt_i == prev_q);
    assign step_bad_o  = prev_valid_q && !step_ok_o && !step_hold_o;
    assign is_wrap_o   = step_ok_o && (prev_q == '0);

endmodule : count_step_checker

// File: rtl/count_wrap_monitor.sv
// -----------------------------------------------------------------------------
// count_wrap_monitor
//
// Watches the output of a free-running down-counter. Flags illegal steps
// (sticky), pulses on every 0 -> all-ones wrap, keeps a saturating wrap total
// and raises a req/ack alarm once WRAP_TARGET wraps have accumulated since the
// last acknowledge.
//
// Ports:
//   clk         in   clock, rising edge
//   reset       in   asynchronous, active-high
//   enable      in   upstream counter running; samples taken only when high
//   cnt_in      in   count from the upstream down-counter
//   alarm_ack   in   acknowledge for alarm_req (ignored outside ALARM)
//   alarm_req   out  high while in ALARM, i.e. until an ack is sampled
//   wrap_pulse  out  one-cycle pulse the cycle after a wrap sample
//   wrap_count  out  total wraps since reset, saturating at all-ones
//   seq_err     out  sticky illegal-step flag, cleared only by reset
//   state_out   out  FSM state: 0 IDLE, 1 TRACK, 2 ALARM
//
// WRAP_TARGET legal range is 1..255.
// -----------------------------------------------------------------------------
module count_wrap_monitor
    import count_mon_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int WRAP_TARGET = 3,
    parameter int WRAP_CNT_W  = WRAP_CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [CNT_W-1:0]      cnt_in,
    input  logic                  alarm_ack,
    output logic                  alarm_req,
    output logic                  wrap_pulse,
    output logic [WRAP_CNT_W-1:0] wrap_count,
    output logic                  seq_err,
    output logic [1:0]            state_out
);

    // since_alarm only has to reach WRAP_TARGET (max 255)
    localparam int              SA_W      = 8;
    localparam logic [SA_W-1:0] SA_TARGET = SA_W'(WRAP_TARGET);

    function automatic logic [WRAP_CNT_W-1:0] sat_inc_wraps(
        input logic [WRAP_CNT_W-1:0] v
    );
        return (&v) ? v : v + WRAP_CNT_W'(1);
    endfunction

    function automatic logic [SA_W-1:0] sat_inc_since(
        input logic [SA_W-1:0] v
    );
        return (v >= SA_TARGET) ? SA_TARGET : v + SA_W'(1);
    endfunction

    logic                  step_ok;
    logic                  step_hold;
    logic                  step_bad;
    logic                  is_wrap;

    logic [1:0]            state_q;
    logic [1:0]            state_d;
    logic [SA_W-1:0]       since_alarm_q;
    logic [SA_W-1:0]       since_alarm_d;
    logic [WRAP_CNT_W-1:0] wrap_count_q;
    logic [WRAP_CNT_W-1:0] wrap_count_d;
    logic                  wrap_pulse_q;
    logic                  wrap_pulse_d;
    logic                  seq_err_q;
    logic                  seq_err_d;

    logic                  checking;
    logic                  wrap_evt;
    logic                  bad_evt;
    logic                  unused_step_flags;

    count_step_checker #(
        .CNT_W (CNT_W)
    ) u_step_checker (
        .clk         (clk),
        .reset       (reset),
        .enable_i    (enable),
        .cnt_i       (cnt_in),
        .step_ok_o   (step_ok),
        .step_hold_o (step_hold),
        .step_bad_o  (step_bad),
        .is_wrap_o   (is_wrap)
    );

    // Legal steps and holds need no action of their own; only wraps and bad
    // steps drive state here.
    assign unused_step_flags = step_ok ^ step_hold;

    // prev_valid is already low in IDLE; the state term keeps the first
    // sample unchecked even if that ever changes.
    assign checking = enable && (state_q != ST_IDLE);
    assign wrap_evt = checking && is_wrap;
    assign bad_evt  = checking && step_bad;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d       = state_q;
        since_alarm_d = since_alarm_q;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_TRACK;
                end
            end
            ST_TRACK: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (wrap_evt) begin
                    since_alarm_d = sat_inc_since(since_alarm_q);
                    if (since_alarm_d == SA_TARGET) begin
                        state_d = ST_ALARM;
                    end
                end
            end
            ST_ALARM: begin
                if (alarm_ack) begin
                    // A wrap on the ack edge opens the next epoch at 1
                    state_d       = enable ? ST_TRACK : ST_IDLE;
                    since_alarm_d = wrap_evt ? SA_W'(1) : '0;
                end else if (wrap_evt) begin
                    since_alarm_d = sat_inc_since(since_alarm_q);
                end
            end
            default: begin
                state_d       = ST_IDLE;
                since_alarm_d = '0;
            end
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // alarm_req is a Moore output, so it rises with the wrap_pulse of the
    // wrap that entered ALARM and falls the cycle after the ack edge.
    always_comb begin
        alarm_req = (state_q == ST_ALARM);
        state_out = state_q;
    end

    // ---------------- Wrap / error bookkeeping ----------------
    always_comb begin
        wrap_pulse_d = wrap_evt;
        wrap_count_d = wrap_evt ? sat_inc_wraps(wrap_count_q) : wrap_count_q;
        seq_err_d    = seq_err_q | bad_evt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            since_alarm_q <= '0;
            wrap_count_q  <= '0;
            wrap_pulse_q  <= 1'b0;
            seq_err_q     <= 1'b0;
        end else begin
            since_alarm_q <= since_alarm_d;
            wrap_count_q  <= wrap_count_d;
            wrap_pulse_q  <= wrap_pulse_d;
            seq_err_q     <= seq_err_d;
        end
    end

    assign wrap_pulse = wrap_pulse_q;
    assign wrap_count = wrap_count_q;
    assign seq_err    = seq_err_q;

endmodule : count_wrap_monitor

// File: tb/tb_count_wrap_monitor.sv
// -----------------------------------------------------------------------------
// tb_count_wrap_monitor
//
// Self-checking bench for count_wrap_monitor (CNT_W=4, WRAP_TARGET=3,
// WRAP_CNT_W=8). Each drive() applies one sample, advances a reference model
// and pushes the expected outputs; the scenario tasks pop and compare after
// the edge, and add directed checks at the points of interest.
// -----------------------------------------------------------------------------
module tb_count_wrap_monitor;

    localparam int CNT_W       = 4;
    localparam int WRAP_TARGET = 3;
    localparam int WRAP_CNT_W  = 8;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  enable;
    logic [CNT_W-1:0]      cnt_in;
    logic                  alarm_ack;
    logic                  alarm_req;
    logic                  wrap_pulse;
    logic [WRAP_CNT_W-1:0] wrap_count;
    logic                  seq_err;
    logic [1:0]            state_out;

    count_wrap_monitor #(
        .CNT_W       (CNT_W),
        .WRAP_TARGET (WRAP_TARGET),
        .WRAP_CNT_W  (WRAP_CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .cnt_in     (cnt_in),
        .alarm_ack  (alarm_ack),
        .alarm_req  (alarm_req),
        .wrap_pulse (wrap_pulse),
        .wrap_count (wrap_count),
        .seq_err    (seq_err),
        .state_out  (state_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       req;
        logic       pulse;
        logic [7:0] wc;
        logic       err;
        logic [1:0] st;
    } obs_t;

    obs_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // reference model state
    logic [1:0] m_st;
    logic [3:0] m_prev;
    logic       m_pv;
    int         m_since;
    int         m_wc;
    logic       m_err;
    logic       m_pulse;

    logic [3:0] cur;
    obs_t       got;
    obs_t       exp_o;

    function automatic obs_t dut_obs();
        return {alarm_req, wrap_pulse, wrap_count, seq_err, state_out};
    endfunction

    task automatic model_reset();
        m_st    = 2'd0;
        m_prev  = 4'd0;
        m_pv    = 1'b0;
        m_since = 0;
        m_wc    = 0;
        m_err   = 1'b0;
        m_pulse = 1'b0;
        sb.delete();
    endtask

    // Apply one sample, update the model, push expectation, step one edge.
    task automatic drive(input logic en, input logic [3:0] c, input logic ack);
        logic [3:0] dec;
        logic       active;
        logic       w;
        logic       bad;
        obs_t       e;
        enable    = en;
        cnt_in    = c;
        alarm_ack = ack;
        dec    = m_prev - 4'd1;
        active = en && m_pv && (m_st != 2'd0);
        w      = active && (m_prev == 4'd0) && (c == 4'd15);
        bad    = active && (c != m_prev) && (c != dec);
        m_pulse = w;
        if (w && m_wc < 255) m_wc++;
        m_err = m_err | bad;
        case (m_st)
            2'd0: if (en) m_st = 2'd1;
            2'd1: begin
                if (!en) m_st = 2'd0;
                else if (w) begin
                    m_since++;
                    if (m_since == WRAP_TARGET) m_st = 2'd2;
                end
            end
            2'd2: begin
                if (ack) begin
                    m_st    = en ? 2'd1 : 2'd0;
                    m_since = w ? 1 : 0;
                end else if (w && m_since < WRAP_TARGET) begin
                    m_since++;
                end
            end
            default: m_st = 2'd0;
        endcase
        m_pv = en;
        if (en) m_prev = c;
        e.req   = (m_st == 2'd2);
        e.pulse = m_pulse;
        e.wc    = 8'(m_wc);
        e.err   = m_err;
        e.st    = m_st;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        enable    = 1'b0;
        alarm_ack = 1'b0;
        cnt_in    = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (dut_obs() !== obs_t'(0))
            $display("FAIL reset_state: got %h, want 0", dut_obs());
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        n_checks++;
        if (state_out !== 2'd0 || alarm_req !== 1'b0)
            $display("FAIL idle_after_release: state=%0d req=%b, want 0 0", state_out, alarm_req);
        else n_pass++;
    endtask

    task automatic test_wrap_stream();
        cur = 4'd15;
        for (int i = 0; i < 33; i++) begin
            drive(1'b1, cur, 1'b0);
            cur = cur - 4'd1;
            exp_o = sb.pop_front(); got = dut_obs(); n_checks++;
            if (got !== exp_o) $display("FAIL sb_wrap_stream[%0d]: got %h want %h", i, got, exp_o);
            else n_pass++;
            if (i == 16) begin
                n_checks++;
                if (wrap_pulse !== 1'b1 || wrap_count !== 8'd1 || seq_err !== 1'b0)
                    $display("FAIL first_wrap: pulse=%b count=%0d err=%b, want 1 1 0", wrap_pulse, wrap_count, seq_err);
                else n_pass++;
            end
            if (i == 17) begin
                n_checks++;
                if (wrap_pulse !== 1'b0)
                    $display("FAIL pulse_width: pulse=%b, want 0", wrap_pulse);
                else n_pass++;
            end
            if (i == 32) begin
                n_checks++;
                if (wrap_pulse !== 1'b1 || wrap_count !== 8'd2 || alarm_req !== 1'b0)
                    $display("FAIL second_wrap: pulse=%b count=%0d req=%b, want 1 2 0", wrap_pulse, wrap_count, alarm_req);
                else n_pass++;
            end
        end
    endtask

    task automatic test_alarm();
        // cur = 14: the 16th drive is the 3rd wrap, the 32nd the 4th
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, cur, 1'b0);
            cur = cur - 4'd1;
            exp_o = sb.pop_front(); got = dut_obs(); n_checks++;
            if (got !== exp_o) $display("FAIL sb_alarm[%0d]: got %h want %h", i, got, exp_o);
            else n_pass++;
            if (i == 15) begin
                n_checks++;
                if (alarm_req !== 1'b1 || wrap_pulse !== 1'b1 || wrap_count !== 8'd3 || state_out !== 2'd2)
                    $display("FAIL alarm_rise: req=%b pulse=%b count=%0d state=%0d, want 1 1 3 2",
                             alarm_req, wrap_pulse, wrap_count, state_out);
                else n_pass++;
            end
        end
        n_checks++;
        if (alarm_req !== 1'b1 || wrap_count !== 8'd4)
            $display("FAIL alarm_held: req=%b count=%0d, want 1 4", alarm_req, wrap_count);
        else n_pass++;
        drive(1'b1, cur, 1'b1);
        cur = cur - 4'd1;
        exp_o = sb.pop_front(); got = dut_obs(); n_checks++;
        if (got !== exp_o) $display("FAIL sb_ack: got %h want %h", got, exp_o);
        else n_pass++;
        n_checks++;
        if (alarm_req !== 1'b0 || state_out !== 2'd1)
            $display("FAIL ack_clear: req=%b state=%0d, want 0 1", alarm_req, state_out);
        else n_pass++;
        // cur = 13: wraps at drives 14, 30, 46
        for (int i = 0; i < 47; i++) begin
            drive(1'b1, cur, 1'b0);
            cur = cur - 4'd1;
            exp_o = sb.pop_front(); got = dut_obs(); n_checks++;
            if (got !== exp_o) $display("FAIL sb_realarm[%0d]: got %h want %h", i, got, exp_o);
            else n_pass++;
            if (i == 30) begin
                n_checks++;
                if (alarm_req !== 1'b0)
                    $display("FAIL realarm_early: req=%b, want 0", alarm_req);
                else n_pass++;
            end
        end
        n_checks++;
        if (alarm_req !== 1'b1 || wrap_count !== 8'd7)
            $display("FAIL realarm: req=%b count=%0d, want 1 7", alarm_req, wrap_count);
        else n_pass++;
    endtask

    task automatic test_enable_gap();
        // cur = 14, in ALARM; run down to the 7 sample
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, cur, 1'b0);
            cur = cur - 4'd1;
            exp_o = sb.pop_front(); got = dut_obs(); n_checks++;
            if (got !== exp_o) $display("FAIL sb_gap_pre[%0d]: got %h want %h", i, got, exp_o);
            else n_pass++;
        end
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 4'd2, 1'b0);
            exp_o = sb.pop_front(); got = dut_obs(); n_checks++;
            if (got !== exp_o) $display("FAIL sb_gap[%0d]: got %h want %h", i, got, exp_o);
            else n_pass++;
        end
        drive(1'b1, 4'd2, 1'b0);
        exp_o = sb.pop_front(); got = dut_obs(); n_checks++;
        if (got !== exp_o) $display("FAIL sb_gap_resume: got %h want %h", got, exp_o);
        else n_pass++;
        n_checks++;
        if (alarm_req !== 1'b1 || seq_err !== 1'b0 || state_out !== 2'd2)
            $display("FAIL gap_resume: req=%b err=%b state=%0d, want 1 0 2", alarm_req, seq_err, state_out);
        else n_pass++;
        drive(1'b1, 4'd1, 1'b0);
        exp_o = sb.pop_front(); got = dut_obs(); n_checks++;
        if (got !== exp_o) $display("FAIL sb_gap_step: got %h want %h", got, exp_o);
        else n_pass++;
        drive(1'b0, 4'd0, 1'b1);
        exp_o = sb.pop_front(); got = dut_obs(); n_checks++;
        if (got !== exp_o) $display("FAIL sb_gap_ack: got %h want %h", got, exp_o);
        else n_pass++;
        n_checks++;
        if (state_out !== 2'd0 || alarm_req !== 1'b0)
            $display("FAIL ack_disabled: state=%0d req=%b, want 0 0", state_out, alarm_req);
        else n_pass++;
        drive(1'b1, 4'd0, 1'b0);
        exp_o = sb.pop_front(); got = dut_obs(); n_checks++;
        if (got !== exp_o) $display("FAIL sb_gap_restart: got %h want %h", got, exp_o);
        else n_pass++;
        cur = 4'd15;
    endtask

    task automatic test_ack_on_wrap();
        // TRACK, prev = 0, cur = 15: wraps at drives 0, 16, 32
        for (int i = 0; i < 33; i++) begin
            drive(1'b1, cur, 1'b0);
            cur = cur - 4'd1;
            exp_o = sb.pop_front(); got = dut_obs(); n_checks++;
            if (got !== exp_o) $display("FAIL sb_aow_pre[%0d]: got %h want %h", i, got, exp_o);
            else n_pass++;
        end
        n_checks++;
        if (alarm_req !== 1'b1 || state_out !== 2'd2)
            $display("FAIL aow_alarm: req=%b state=%0d, want 1 2", alarm_req, state_out);
        else n_pass++;
        for (int i = 0; i < 15; i++) begin
            drive(1'b1, cur, 1'b0);
            cur = cur - 4'd1;
            exp_o = sb.pop_front(); got = dut_obs(); n_checks++;
            if (got !== exp_o) $display("FAIL sb_aow_run[%0d]: got %h want %h", i, got, exp_o);
            else n_pass++;
        end
        drive(1'b1, cur, 1'b1);
        cur = cur - 4'd1;
        exp_o = sb.pop_front(); got = dut_obs(); n_checks++;
        if (got !== exp_o) $display("FAIL sb_aow_edge: got %h want %h", got, exp_o);
        else n_pass++;
        n_checks++;
        if (alarm_req !== 1'b0 || wrap_pulse !== 1'b1 || state_out !== 2'd1)
            $display("FAIL ack_on_wrap: req=%b pulse=%b state=%0d, want 0 1 1", alarm_req, wrap_pulse, state_out);
        else n_pass++;
        // since_alarm = 1 now, so the 2nd further wrap re-alarms
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, cur, 1'b0);
            cur = cur - 4'd1;
            exp_o = sb.pop_front(); got = dut_obs(); n_checks++;
            if (got !== exp_o) $display("FAIL sb_aow_post[%0d]: got %h want %h", i, got, exp_o);
            else n_pass++;
            if (i == 15) begin
                n_checks++;
                if (alarm_req !== 1'b0 || wrap_pulse !== 1'b1)
                    $display("FAIL aow_one_more: req=%b pulse=%b, want 0 1", alarm_req, wrap_pulse);
                else n_pass++;
            end
        end
        n_checks++;
        if (alarm_req !== 1'b1 || wrap_pulse !== 1'b1)
            $display("FAIL aow_realarm: req=%b pulse=%b, want 1 1", alarm_req, wrap_pulse);
        else n_pass++;
    endtask

    task automatic test_seq_err();
        logic [3:0] vals [6];
        logic       want [6];
        vals = '{4'd9, 4'd9, 4'd8, 4'd5, 4'd4, 4'd3};
        want = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 6; i++) begin
            // first sample disabled so 9 starts a fresh, unchecked run
            drive(i != 0, vals[i], 1'b0);
            exp_o = sb.pop_front(); got = dut_obs(); n_checks++;
            if (got !== exp_o) $display("FAIL sb_seq[%0d]: got %h want %h", i, got, exp_o);
            else n_pass++;
            n_checks++;
            if (seq_err !== want[i])
                $display("FAIL seq_err[%0d]: got %b want %b", i, seq_err, want[i]);
            else n_pass++;
        end
        n_checks++;
        if (alarm_req !== 1'b1)
            $display("FAIL seq_alarm_kept: req=%b, want 1", alarm_req);
        else n_pass++;
    endtask

    task automatic test_saturation();
        reset  = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        cur = 4'd15;
        // 260 wraps: first 15 is unchecked, wraps at drives 16, 32, ...
        for (int i = 0; i < 16 * 260 + 1; i++) begin
            drive(1'b1, cur, 1'b0);
            cur = cur - 4'd1;
            exp_o = sb.pop_front(); got = dut_obs(); n_checks++;
            if (got !== exp_o) $display("FAIL sb_sat[%0d]: got %h want %h", i, got, exp_o);
            else n_pass++;
        end
        n_checks++;
        if (wrap_count !== 8'd255 || alarm_req !== 1'b1)
            $display("FAIL wrap_saturate: count=%0d req=%b, want 255 1", wrap_count, alarm_req);
        else n_pass++;
        drive(1'b1, cur, 1'b1);
        cur = cur - 4'd1;
        exp_o = sb.pop_front(); got = dut_obs(); n_checks++;
        if (got !== exp_o) $display("FAIL sb_sat_ack: got %h want %h", got, exp_o);
        else n_pass++;
        for (int i = 0; i < 47; i++) begin
            drive(1'b1, cur, 1'b0);
            cur = cur - 4'd1;
            exp_o = sb.pop_front(); got = dut_obs(); n_checks++;
            if (got !== exp_o) $display("FAIL sb_sat_post[%0d]: got %h want %h", i, got, exp_o);
            else n_pass++;
            if (i == 30) begin
                n_checks++;
                if (alarm_req !== 1'b0)
                    $display("FAIL since_sat_early: req=%b, want 0", alarm_req);
                else n_pass++;
            end
        end
        n_checks++;
        if (alarm_req !== 1'b1 || wrap_count !== 8'd255)
            $display("FAIL since_sat_realarm: req=%b count=%0d, want 1 255", alarm_req, wrap_count);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        logic [3:0] head [8];
        reset  = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        head = '{4'd9, 4'd8, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, head[i], 1'b0);
            exp_o = sb.pop_front(); got = dut_obs(); n_checks++;
            if (got !== exp_o) $display("FAIL sb_ar_head[%0d]: got %h want %h", i, got, exp_o);
            else n_pass++;
        end
        cur = 4'd15;
        for (int i = 0; i < 65; i++) begin
            drive(1'b1, cur, 1'b0);
            cur = cur - 4'd1;
            exp_o = sb.pop_front(); got = dut_obs(); n_checks++;
            if (got !== exp_o) $display("FAIL sb_ar_run[%0d]: got %h want %h", i, got, exp_o);
            else n_pass++;
        end
        n_checks++;
        if (wrap_count !== 8'd5 || seq_err !== 1'b1 || alarm_req !== 1'b1 || state_out !== 2'd2)
            $display("FAIL pre_async: count=%0d err=%b req=%b state=%0d, want 5 1 1 2",
                     wrap_count, seq_err, alarm_req, state_out);
        else n_pass++;
        // mid-cycle: 4 ns after the last edge, 6 ns before the next
        #3;
        reset = 1'b1;
        #1;
        n_checks++;
        if (dut_obs() !== obs_t'(0))
            $display("FAIL async_reset: got %h, want 0 before next clk", dut_obs());
        else n_pass++;
        enable = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        test_reset();
        test_wrap_stream();
        test_alarm();
        test_enable_gap();
        test_ack_on_wrap();
        test_seq_err();
        test_saturation();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_count_wrap_monitor

// File: doc/count_wrap_monitor.md
Name: count_wrap_monitor

Overview:
- Sits directly downstream of the free-running 4-bit down-counter and consumes its count output.
- Checks each new sample against the previous one and flags any illegal step.
- Emits a one-cycle pulse on every 0 -> MAX wrap and keeps a saturating total of wraps.
- Raises a req/ack alarm after WRAP_TARGET wraps, so software or a later stage can handle countdown epochs.

Parameters:
- CNT_W, 4: width of the monitored count (cnt_in).
- WRAP_TARGET, 3: number of wraps that triggers alarm_req. Legal range is 1..255.
- WRAP_CNT_W, 8: width of the wrap_count output.

Ports:
- clk  input  1  Sole clock, rising edge.
- reset  input  1  Asynchronous, active-high. One clock; reset is asynchronous and active-high.
- enable  input  1  High when the upstream counter is running; samples are taken only when high.
- cnt_in  input  CNT_W  Count value from the upstream down-counter.
- alarm_ack  input  1  Acknowledge for alarm_req.
- alarm_req  output  1  Alarm request; held until acknowledged.
- wrap_pulse  output  1  One-cycle pulse for each detected wrap.
- wrap_count  output  WRAP_CNT_W  Total wraps since reset; saturates at all-ones.
- seq_err  output  1  Sticky illegal-step flag.
- state_out  output  2  Current FSM state: 0 IDLE, 1 TRACK, 2 ALARM.

Behaviour:
- Reset (async assert, released on clk):
  - alarm_req, wrap_pulse, seq_err = 0; wrap_count = 0; state = IDLE.
  - Internal prev register, prev_valid and since_alarm counter = 0.
- Sampling happens only on a rising clk with enable=1.
- enable=0:
  - prev_valid is cleared and wrap_pulse is 0.
  - A pending ALARM is kept, and ack is still honoured.
  - TRACK returns to IDLE.
- IDLE: the first enabled sample loads prev <= cnt_in, sets prev_valid, and moves to TRACK. No check is made on that sample.
- Step check in TRACK and ALARM, with prev_valid=1. Let exp = prev - 1 mod 2^CNT_W.
  - cnt_in == exp: legal step.
  - cnt_in == prev: legal hold (stall), no action.
  - Anything else: seq_err <= 1 (sticky). It is not counted as a wrap.
  - In every case prev <= cnt_in.
- Wrap: a legal step with prev == 0 and cnt_in == 2^CNT_W-1.
  - wrap_pulse goes high for exactly the cycle after the sampling edge (latency 1).
  - wrap_count increments, saturating at all-ones.
  - since_alarm increments.
- Alarm entry, from TRACK: when a wrap makes since_alarm == WRAP_TARGET, go to ALARM.
  - alarm_req rises in the same cycle as that wrap_pulse.
- ALARM state:
  - Tracking, checking and wrap counting continue. since_alarm saturates at WRAP_TARGET.
  - alarm_req is held high until alarm_ack=1 is sampled.
  - On the ack edge: alarm_req <= 0, state <= TRACK (IDLE if enable=0), since_alarm <= 0.
  - A wrap on the same edge as the ack counts as since_alarm = 1 after the clear.
- alarm_ack outside ALARM is ignored.
- seq_err clears only on reset.
- Reset mid-operation forces all reset values immediately, without waiting for clk. Monitoring restarts from IDLE.

Decomposition:
- Package count_mon_pkg holds:
  - State localparams ST_IDLE=2'd0, ST_TRACK=2'd1, ST_ALARM=2'd2.
  - Default widths CNT_W_DEF=4 and WRAP_CNT_W_DEF=8.
- Sub-module count_step_checker (parameter CNT_W):
  - Owns prev and prev_valid.
  - Produces registered-ready combinational flags step_ok, step_hold, step_bad and is_wrap.
  - The FSM, counters and alarm handshake stay in the top module.

Test Plan:
- Reset release, enable=1, cnt_in driven 15,14,..,0,15,...:
  - wrap_pulse every 16 cycles, first one cycle after the 0->15 sample.
  - wrap_count = 1, 2, 3...; seq_err stays 0.
- Same stream, WRAP_TARGET=3:
  - alarm_req rises with the 3rd wrap_pulse and stays high while alarm_ack=0 through a 4th wrap (wrap_count=4).
  - Ack pulse -> alarm_req=0 next cycle, state_out=1.
  - Next alarm after 3 more wraps.
- Stream 9,8,5:
  - seq_err=1 after the 5 sample and stays 1.
  - Continuing 4,3 gives no new error. 5->4 is checked against the new prev.
- enable=0 for 5 cycles during ALARM, with cnt_in jumping from 7 to 2:
  - alarm_req stays 1 and seq_err stays 0 (first sample is unchecked).
  - state_out goes to 0 once acked while disabled.
- Ack on the same edge as a wrap:
  - alarm_req clears, wrap_pulse=1, internal since_alarm=1.
  - Next alarm follows after 2 further wraps.
- Assert reset asynchronously mid-ALARM with wrap_count=5 and seq_err=1:
  - All outputs drop to 0 before the next clk edge; state_out=0.
